// File: rtl/imem_loader.sv
// Run-time instruction memory loader: header byte N, then 4*N big-endian bytes written as words; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined. All outputs registered; one byte per cycle, in_valid low stalls.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [AW:0] W_ONE = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [1:0]  bidx;
    logic [AW:0] wcnt;
    logic [AW:0] nwords;
    logic [23:0] asm_q;
    logic        hs;
    logic        last_word;
    logic        hdr_big;
    logic        rdy_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  acc;
`endif

    assign hs        = in_valid && in_ready;
    assign last_word = (wcnt + W_ONE) == nwords;
    assign hdr_big   = int'({24'd0, in_data}) > DEPTH;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy_nxt   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR: begin
                if (hs) begin
                    if (in_data == 8'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = DONE;
`endif
                    else if (hdr_big)
                        state_nxt = ERR;
                    else
                        state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (hs && bidx == 2'd3 && last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (hs) state_nxt = (in_data == acc) ? DONE : ERR;
`endif
            DONE: if (start) state_nxt = HDR;
            ERR:  if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
        rdy_nxt = (state_nxt == HDR) || (state_nxt == LOAD) || (state_nxt == CHK);
`else
        rdy_nxt = (state_nxt == HDR) || (state_nxt == LOAD);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            bidx      <= 2'd0;
            wcnt      <= '0;
            nwords    <= '0;
            asm_q     <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc       <= 8'd0;
`endif
        end else begin
            mem_we   <= 1'b0;
            in_ready <= rdy_nxt;
            busy     <= rdy_nxt;
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERR);
            // Release the CPU only after a full cycle in DONE so the last word has landed.
            cpu_rst  <= !(state == DONE && state_nxt == DONE);

            if (start && (state == IDLE || state == DONE || state == ERR)) begin
                bidx   <= 2'd0;
                wcnt   <= '0;
                nwords <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                acc    <= 8'd0;
`endif
            end

            if (hs) begin
                case (state)
                    HDR: begin
                        nwords <= (AW+1)'(in_data);
                        bidx   <= 2'd0;
                        wcnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc    <= in_data;
`endif
                    end
                    LOAD: begin
                        asm_q <= {asm_q[15:0], in_data};
                        bidx  <= bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        acc   <= acc ^ in_data;
`endif
                        if (bidx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {asm_q, in_data};
                            mem_addr  <= 32'(wcnt[AW-1:0]);
                            wcnt      <= wcnt + W_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; covers both the plain and the checksum build.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_rst, busy, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int base;

    logic [7:0] t1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    logic [7:0] t3 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        // flags: {in_ready, mem_we, cpu_rst, busy, done, error}
        check("reset_flags", 32'({in_ready, mem_we, cpu_rst, busy, done, error}), 32'b001000);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_rdy", 32'(in_ready), 32'd0);

        // N=2 back-to-back
        pulse_start();
        check("hdr_rdy", 32'(in_ready), 32'd1);
        send(8'd2);
        for (int i = 0; i < 8; i++) begin
            send(t1[i]);
            if (i == 3) begin
                check("w0_we", 32'(mem_we), 32'd1);
                check("w0_addr", mem_addr, 32'd0);
                check("w0_data", mem_wdata, 32'h20080005);
            end
            if (i == 4) check("w0_pulse_end", 32'(mem_we), 32'd0);
            if (i == 6) check("done_early", 32'(done), 32'd0);
            if (i == 7) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                check("w1_done_pending", 32'(done), 32'd0);
`else
                check("w1_done", 32'(done), 32'd1);
`endif
                check("w1_we", 32'(mem_we), 32'd1);
                check("w1_addr", mem_addr, 32'd1);
                check("w1_data", mem_wdata, 32'h2009000A);
                check("w1_cpu_rst_held", 32'(cpu_rst), 32'd1);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h02 ^ 8'h20 ^ 8'h08 ^ 8'h05 ^ 8'h20 ^ 8'h09 ^ 8'h0A);
        check("t1_chk_done", 32'(done), 32'd1);
`endif
        tick();
        check("t1_cpu_rst_rel", 32'(cpu_rst), 32'd0);
        check("t1_done_hold", 32'(done), 32'd1);
        check("t1_we_cnt", 32'(we_cnt), 32'd2);

        // N=65 rejected
        pulse_start();
        check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        send(8'd65);
        check("big_flags", 32'({in_ready, cpu_rst, busy, done, error}), 32'b01001);
        tick();
        check("big_sticky", 32'(error), 32'd1);
        check("big_no_we", 32'(we_cnt), 32'd2);
        pulse_start();
        check("err_restart", 32'({busy, error}), 32'b10);

        // N=1 with in_valid toggling
        send(8'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            in_data  = 8'h55;
            tick();
            check("tog_no_we", 32'(mem_we), 32'd0);
            send(t3[i]);
        end
        check("tog_we", 32'(mem_we), 32'd1);
        check("tog_addr", mem_addr, 32'd0);
        check("tog_data", mem_wdata, 32'hAABBCCDD);
        check("tog_no_early_we", 32'(we_cnt), 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h01);
`endif
        check("tog_done", 32'(done), 32'd1);
        tick();
        check("tog_we_cnt", 32'(we_cnt), 32'd3);

        // rst after 6 of 8 data bytes
        base = we_cnt;
        pulse_start();
        send(8'd2);
        for (int i = 0; i < 6; i++) send(t1[i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_flags", 32'({in_ready, mem_we, cpu_rst, busy, done, error}), 32'b001000);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_we_cnt", 32'(we_cnt - base), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // checksum good then bad
        pulse_start();
        send(8'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05);
        check("ck_good", 32'({done, error}), 32'b10);
        check("ck_good_data", mem_wdata, 32'h01020304);
        pulse_start();
        send(8'd1);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h00);
        check("ck_bad", 32'({done, error}), 32'b01);
        check("ck_bad_data", mem_wdata, 32'h01020304);
        check("ck_bad_addr", mem_addr, 32'd0);
        tick();
        check("ck_we_cnt", 32'(we_cnt - base), 32'd3);
`endif

        // N=0
        base = we_cnt;
        pulse_start();
        send(8'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        check("n0_done", 32'(done), 32'd1);
        check("n0_cpu_rst_held", 32'(cpu_rst), 32'd1);
        tick();
        check("n0_cpu_rst_rel", 32'(cpu_rst), 32'd0);
        check("n0_no_we", 32'(we_cnt - base), 32'd0);
        pulse_start();
        check("n0_restart", 32'({cpu_rst, busy, done}), 32'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
